pool_window_buffer: RTL

Upstream feeder for the 3-channel max-pool stage. It accepts the raster-order conv output stream, one 16-bit signed pixel per channel per valid beat. It builds 2x2 stride-2 pooling windows using a half-row buffer of partial maxima. Once per completed window it presents the window's last pixel, the running max of the other three pixels, and a one-cycle enable per channel to the pool PEs.

---
 rtl/pool_window_buffer.sv | 120 ++++++++++++
 1 files changed

// File: rtl/pool_window_buffer.sv
// pool_window_buffer
//   Feeds the 3-channel max-pool PEs. It takes a raster-order conv output stream
//   and builds 2x2 stride-2 windows. On even rows, the pairwise max of each pixel
//   pair is parked in a half-row buffer. On odd rows, that entry is combined with
//   the held left pixel. The 4th pixel is presented with the max of the other three.
//
//   Optional feature: define POOL_RELU_EN to clamp negative input pixels to 0
//   before they are held or buffered (fused ReLU).
//
// Ports
//   clk, n_reset          clock, asynchronous active-low reset
//   start                 frame-start pulse (priority over in_valid, beat dropped)
//   in_valid              pixel beat valid, gaps allowed, no backpressure
//   in_pixel[3:1]         signed conv output per channel
//   input_feature[3:1]    4th window pixel (registered)
//   last_max[3:1]         max of first three window pixels (registered)
//   enable_pool[3:1]      one-cycle window-complete strobe per channel
//   pool_start            start delayed by one cycle
//   frame_done            pulses with the enable of the frame's final window
module pool_window_buffer #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ROW_LEN  = 24,
  parameter int unsigned NUM_ROWS = 24
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic                     start,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_pixel      [3:1],
  output logic signed [DATA_W-1:0] input_feature [3:1],
  output logic signed [DATA_W-1:0] last_max      [3:1],
  output logic [3:1]               enable_pool,
  output logic                     pool_start,
  output logic                     frame_done
);

  localparam int unsigned COL_W = $clog2(ROW_LEN);
  localparam int unsigned ROW_W = $clog2(NUM_ROWS);
  localparam int unsigned HALF  = ROW_LEN / 2;
  localparam int unsigned IDX_W = (HALF > 1) ? $clog2(HALF) : 1;

  logic [COL_W-1:0]         col;
  logic [ROW_W-1:0]         row;
  logic [IDX_W-1:0]         idx;
  logic                     last_col;
  logic                     last_row;
  logic signed [DATA_W-1:0] pix    [3:1];
  logic signed [DATA_W-1:0] hold   [3:1];
  logic signed [DATA_W-1:0] rowbuf [3:1][HALF];

  function automatic logic signed [DATA_W-1:0] smax(input logic signed [DATA_W-1:0] a,
                                                    input logic signed [DATA_W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  always_comb begin
    for (int c = 1; c <= 3; c++) begin
`ifdef POOL_RELU_EN
      pix[c] = in_pixel[c][DATA_W-1] ? '0 : in_pixel[c];
`else
      pix[c] = in_pixel[c];
`endif
    end
  end

  assign idx      = IDX_W'(col >> 1);
  assign last_col = (col == COL_W'(ROW_LEN - 1));
  assign last_row = (row == ROW_W'(NUM_ROWS - 1));

  // Partial maxima of the even row. The buffer needs no reset: an odd row only
  // reads entries that the even row above it has already written in this frame.
  always_ff @(posedge clk) begin
    if (!start && in_valid && !row[0] && col[0]) begin
      for (int c = 1; c <= 3; c++) rowbuf[c][idx] <= smax(hold[c], pix[c]);
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      col         <= '0;
      row         <= '0;
      enable_pool <= '0;
      pool_start  <= 1'b0;
      frame_done  <= 1'b0;
      for (int c = 1; c <= 3; c++) begin
        hold[c]          <= '0;
        input_feature[c] <= '0;
        last_max[c]      <= '0;
      end
    end else begin
      pool_start  <= start;
      enable_pool <= '0;
      frame_done  <= 1'b0;
      if (start) begin
        col <= '0;
        row <= '0;
        for (int c = 1; c <= 3; c++) hold[c] <= '0;
      end else if (in_valid) begin
        if (last_col) begin
          col <= '0;
          row <= last_row ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (!col[0]) begin
          // Left pixel of a pair, on both even and odd rows.
          for (int c = 1; c <= 3; c++) hold[c] <= pix[c];
        end else if (row[0]) begin
          for (int c = 1; c <= 3; c++) begin
            input_feature[c] <= pix[c];
            last_max[c]      <= smax(rowbuf[c][idx], hold[c]);
          end
          enable_pool <= '1;
          frame_done  <= last_row && last_col;
        end
      end
    end
  end

endmodule
